// File: rtl/fetch_queue_pkg.sv
// Shared defaults for the instruction fetch queue: data widths, depth and a
// small helper used by the elaboration-time parameter checks.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_PC_W  = 64;
  localparam int FQ_INS_W = 32;

  function automatic bit isPow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// Register array holding {pc, instruction} entries: one synchronous write
// port, one combinational read port, synchronously cleared on reset.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = FQ_PC_W + FQ_INS_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between instruction memory and decode. Holds the
// PC while full; a flush discards all buffered entries in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PC_W  = FQ_PC_W,
  parameter int INS_W = FQ_INS_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [PC_W-1:0]            enq_pc,
  input  logic [INS_W-1:0]           enq_ins,
  output logic                       enq_ready,
  output logic                       pc_write,
  output logic                       deq_valid,
  output logic [PC_W-1:0]            deq_pc,
  output logic [INS_W-1:0]           deq_ins,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DATA_W = PC_W + INS_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  if (!isPow2(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_enqFire;
  logic              w_deqFire;
  logic [DATA_W-1:0] w_rdata;

  // Ready/valid come only from the registered count, so decode's ready never
  // reaches the fetch side combinationally.
  assign enq_ready = (r_count != FULL_COUNT);
  assign pc_write  = enq_ready;
  assign deq_valid = (r_count != '0);
  assign count     = r_count;

  assign w_enqFire = enq_valid & enq_ready & ~flush;
  assign w_deqFire = deq_valid & deq_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_enqFire) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_deqFire) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_enqFire, w_deqFire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  fq_storage #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(PTR_W)
  ) u_storage (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_enqFire),
    .i_waddr(r_wrPtr),
    .i_wdata({enq_pc, enq_ins}),
    .i_raddr(r_rdPtr),
    .o_rdata(w_rdata)
  );

  assign deq_pc  = w_rdata[DATA_W-1:INS_W];
  assign deq_ins = w_rdata[INS_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= FULL_COUNT);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: every accepted enqueue is pushed to a
// queue, and the head of that queue must match whatever decode sees.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;
  localparam int INS_W = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic [PC_W-1:0]  enq_pc = '0;
  logic [INS_W-1:0] enq_ins = '0;
  logic             enq_ready;
  logic             pc_write;
  logic             deq_valid;
  logic [PC_W-1:0]  deq_pc;
  logic [INS_W-1:0] deq_ins;
  logic             deq_ready = 1'b0;
  logic [CNT_W-1:0] count;

  entry_t scoreboard[$];
  int     checkCount = 0;
  int     failCount = 0;
  bit     modelValid = 0;
  bit     zeroExpected = 0;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH(DEPTH),
    .PC_W (PC_W),
    .INS_W(INS_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .enq_valid(enq_valid),
    .enq_pc   (enq_pc),
    .enq_ins  (enq_ins),
    .enq_ready(enq_ready),
    .pc_write (pc_write),
    .deq_valid(deq_valid),
    .deq_pc   (deq_pc),
    .deq_ins  (deq_ins),
    .deq_ready(deq_ready),
    .count    (count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output against the scoreboard's current state.
  task automatic checkState();
    int n;
    n = scoreboard.size();
    checkOutput("count", 64'(count), 64'(n));
    checkOutput("deq_valid", 64'(deq_valid), 64'(n != 0));
    checkOutput("enq_ready", 64'(enq_ready), 64'(n != DEPTH));
    checkOutput("pc_write", 64'(pc_write), 64'(n != DEPTH));
    if (n != 0) begin
      checkOutput("deq_pc", deq_pc, scoreboard[0].pc);
      checkOutput("deq_ins", 64'(deq_ins), 64'(scoreboard[0].ins));
    end else if (zeroExpected) begin
      checkOutput("deq_pc_zero", deq_pc, 64'h0);
      checkOutput("deq_ins_zero", 64'(deq_ins), 64'h0);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, then advance the model.
  task automatic applyStimulus(input logic rst, input logic fl, input logic ev,
                               input logic [PC_W-1:0] pc, input logic [INS_W-1:0] ins,
                               input logic dr);
    bit doEnq;
    bit doDeq;
    @(negedge clk);
    if (modelValid) checkState();
    reset     = rst;
    flush     = fl;
    enq_valid = ev;
    enq_pc    = pc;
    enq_ins   = ins;
    deq_ready = dr;
    @(posedge clk);
    if (rst) begin
      scoreboard.delete();
      zeroExpected = 1;
      modelValid   = 1;
    end else if (fl) begin
      scoreboard.delete();
      zeroExpected = 0;
    end else begin
      doDeq = dr && (scoreboard.size() > 0);
      doEnq = ev && (scoreboard.size() < DEPTH);
      if (doDeq) void'(scoreboard.pop_front());
      if (doEnq) begin
        scoreboard.push_back('{pc: pc, ins: ins});
        zeroExpected = 0;
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic enqOnly(input logic [PC_W-1:0] pc, input logic [INS_W-1:0] ins);
    applyStimulus(1'b0, 1'b0, 1'b1, pc, ins, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle();

    // Fill to capacity, then offer a fifth entry that must be dropped.
    for (int i = 0; i < 4; i++) enqOnly(64'(4 * i), 32'hA0 + 32'(i));
    enqOnly(64'd16, 32'hA4);
    idle();

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle();

    // Streaming across pointer wrap with one entry always in flight.
    enqOnly(64'h20, 32'hB0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h20 + 64'(4 * i), 32'hB0 + 32'(i), 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle();

    // Flush with both enqueue and dequeue requested in the same cycle.
    for (int i = 0; i < 3; i++) enqOnly(64'h40 + 64'(4 * i), 32'hC0 + 32'(i));
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h80, 32'hCF, 1'b1);
    idle();
    enqOnly(64'h100, 32'hD0);
    idle();

    // Reset while holding two entries and offering a third.
    enqOnly(64'h104, 32'hD1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h108, 32'hD2, 1'b0);
    idle();
    idle();

    @(negedge clk);
    checkState();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
